muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (rs1_dout, rs2_dout) and returns a 32-bit result plus destination index for the rd_din/rd write port.
- Multi-cycle: the control unit stalls PC/fetch while busy is high, then asserts RegWrite on the done pulse.
- Radix-2 shift-add multiplier and restoring divider share one 64-bit working register.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_signfix.sv | 46 ++++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-signedness helpers for the
// iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DXLEN       = 2 * XLEN;
  localparam int unsigned MULDIV_ITER = 32;
  localparam int unsigned CNT_W       = $clog2(MULDIV_ITER);

  localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing control unit and muldiv_unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Operand magnitude extraction on the way in and sign correction / result
// selection on the way out of the unsigned iterative core.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  output logic             sign_a_c,
  output logic             sign_b_c,
  output logic [XLEN-1:0]  abs_a_c,
  output logic [XLEN-1:0]  abs_b_c,
  input  logic [2:0]       funct3_q,
  input  logic             sign_a_q,
  input  logic             sign_b_q,
  input  logic [DXLEN-1:0] work,
  output logic [XLEN-1:0]  result_c
);

  // Magnitudes of the incoming operands.
  always_comb begin
    sign_a_c = signed_a(funct3) & op_a[XLEN-1];
    sign_b_c = signed_b(funct3) & op_b[XLEN-1];
    abs_a_c  = sign_a_c ? (~op_a + XLEN'(1)) : op_a;
    abs_b_c  = sign_b_c ? (~op_b + XLEN'(1)) : op_b;
  end

  // Sign-correct the finished working register and pick the requested half.
  always_comb begin
    logic [DXLEN-1:0] prod;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    prod = (sign_a_q ^ sign_b_q) ? (~work + DXLEN'(1)) : work;
    quo  = work[XLEN-1:0];
    rem  = work[DXLEN-1:XLEN];
    if (sign_a_q ^ sign_b_q) quo = ~quo + XLEN'(1);
    if (sign_a_q)            rem = ~rem + XLEN'(1);
    unique case (funct3_q)
      FUNCT3_MUL:                             result_c = prod[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: result_c = prod[DXLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                result_c = quo;
      default:                                result_c = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: radix-2 shift-add multiply and restoring
// divide sharing one 64-bit working register, one bit per clock.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  muldiv_state_e    state_q, state_next;
  logic [CNT_W-1:0] cnt_q;
  logic             primed_q, special_q;
  logic [XLEN-1:0]  spec_res_q;
  logic [2:0]       funct3_q;
  logic             sign_a_q, sign_b_q;
  logic [XLEN-1:0]  abs_a_q, abs_b_q;
  logic [DXLEN-1:0] work_q;
  logic [4:0]       rd_q;
  logic             busy_q, done_q;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       rd_out_q;

  logic             accept, prime, step, finish;
  logic             sign_a_c, sign_b_c, special_c;
  logic [XLEN-1:0]  abs_a_c, abs_b_c, spec_res_c, result_c;
  logic [DXLEN-1:0] step_c;

  muldiv_signfix u_signfix (
    .funct3   (bus.funct3),
    .op_a     (bus.op_a),
    .op_b     (bus.op_b),
    .sign_a_c (sign_a_c),
    .sign_b_c (sign_b_c),
    .abs_a_c  (abs_a_c),
    .abs_b_c  (abs_b_c),
    .funct3_q (funct3_q),
    .sign_a_q (sign_a_q),
    .sign_b_q (sign_b_q),
    .work     (step_c),
    .result_c (result_c)
  );

  // Divide-by-zero and signed-overflow results are known at accept time.
  always_comb begin
    logic div_zero, ovf;
    div_zero   = bus.funct3[2] && (bus.op_b == '0);
    ovf        = ((bus.funct3 == FUNCT3_DIV) || (bus.funct3 == FUNCT3_REM)) &&
                 (bus.op_a == XLEN'(32'h8000_0000)) && (bus.op_b == '1);
    special_c  = div_zero || ovf;
    spec_res_c = '0;
    if (div_zero)  spec_res_c = bus.funct3[1] ? bus.op_a : '1;
    else if (ovf)  spec_res_c = bus.funct3[1] ? '0 : XLEN'(32'h8000_0000);
  end

  // One shift-add or restoring-subtract step on the working register.
  always_comb begin
    logic [XLEN:0]   sum, rem33;
    logic [XLEN-1:0] diff;
    logic            ge;
    sum    = {1'b0, work_q[DXLEN-1:XLEN]} + (work_q[0] ? {1'b0, abs_b_q} : '0);
    rem33  = work_q[DXLEN-1:XLEN-1];
    ge     = rem33 >= {1'b0, abs_b_q};
    diff   = rem33[XLEN-1:0] - abs_b_q;
    if (funct3_q[2])
      step_c = ge ? {diff, work_q[XLEN-2:0], 1'b1}
                  : {rem33[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
    else
      step_c = {sum, work_q[XLEN-1:1]};
  end

  // First CALC cycle primes the working register or retires a special case.
  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    prime      = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          accept     = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_next = ST_IDLE;
        end else if (!primed_q) begin
          if (special_q) begin
            finish     = 1'b1;
            state_next = ST_DONE;
          end else begin
            prime = 1'b1;
          end
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_W'(MULDIV_ITER - 1)) begin
            finish     = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      funct3_q   <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      abs_a_q    <= '0;
      abs_b_q    <= '0;
      work_q     <= '0;
      rd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      state_q <= state_next;
      busy_q  <= (state_next != ST_IDLE);
      done_q  <= (state_next == ST_DONE);
      if (accept) begin
        funct3_q   <= bus.funct3;
        rd_q       <= bus.rd_in;
        sign_a_q   <= sign_a_c;
        sign_b_q   <= sign_b_c;
        abs_a_q    <= abs_a_c;
        abs_b_q    <= abs_b_c;
        special_q  <= special_c;
        spec_res_q <= spec_res_c;
        primed_q   <= 1'b0;
        cnt_q      <= '0;
      end
      if (prime) begin
        work_q   <= {XLEN'(0), abs_a_q};
        primed_q <= 1'b1;
      end
      if (step) begin
        work_q <= step_c;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (finish) begin
        result_q <= special_q ? spec_res_q : result_c;
        rd_out_q <= rd_q;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, special cases,
// flush and asynchronous reset mid-operation.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_pass    = 0;
  int          n_total   = 0;
  int          done_seen = 0;
  logic [31:0] last_res  = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got result %h rd %0d, expected no done pulse",
                 bus.result, bus.rd_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_out", 32'(bus.rd_out), 32'(e.rd));
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] res, input int lat_exp);
    exp_t e;
    int   lat;
    bit   got;
    e.res = res;
    e.rd  = rd;
    exp_q.push_back(e);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.funct3 = ~f3;
    bus.op_a   = ~a;
    bus.op_b   = ~b;
    bus.rd_in  = ~rd;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (i == 0) chk({name, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.done) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL %s_timeout: got no done in 60 cycles, expected latency %0d", name, lat_exp);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(lat_exp));
      last_res = res;
    end
    @(posedge clk); #1;
    chk({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_result", bus.result,      32'd0);
    chk("rst_rd",     32'(bus.rd_out), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("mul",     FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("mulh",    FUNCT3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 33);
    run_op("mulhu",   FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
    run_op("mulhsu",  FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
    run_op("div",     FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    run_op("rem",     FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    run_op("divu",    FUNCT3_DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        33);
    run_op("remu",    FUNCT3_REMU,   32'd100,        32'd7,         5'd12, 32'd2,         33);
    run_op("divu0",   FUNCT3_DIVU,   32'h0000_1234,  32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run_op("rem_ovf", FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);
    run_op("div_ovf", FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run_op("rem0",    FUNCT3_REM,    32'hFFFF_FFF9,  32'd0,         5'd0,  32'hFFFF_FFF9, 1);

    // Flush in CALC cycle 10, with a stray start issued while busy.
    base       = done_seen;
    bus.start  = 1'b1;
    bus.funct3 = FUNCT3_MUL;
    bus.op_a   = 32'd5;
    bus.op_b   = 32'd6;
    bus.rd_in  = 5'd9;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.funct3 = FUNCT3_DIVU;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.flush  = 1'b1;
    @(posedge clk); #1;
    bus.flush  = 1'b0;
    @(negedge clk);
    chk("flush_busy",   32'(bus.busy), 32'd0);
    chk("flush_done",   32'(bus.done), 32'd0);
    chk("flush_result", bus.result,    last_res);
    repeat (45) @(posedge clk);
    @(negedge clk);
    chk("flush_no_done", 32'(done_seen - base), 32'd0);
    chk("flush_hold",    bus.result,            last_res);
    chk("flush_idle",    32'(bus.busy),         32'd0);

    // Asynchronous reset in CALC cycle 20.
    @(posedge clk); #1;
    base       = done_seen;
    bus.start  = 1'b1;
    bus.funct3 = FUNCT3_MULHU;
    bus.op_a   = 32'd9;
    bus.op_b   = 32'd9;
    bus.rd_in  = 5'd3;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy),   32'd0);
    chk("arst_done",   32'(bus.done),   32'd0);
    chk("arst_result", bus.result,      32'd0);
    chk("arst_rd",     32'(bus.rd_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_seen - base), 32'd0);
    run_op("mul_after_reset", FUNCT3_MUL, 32'd3, 32'd4, 5'd7, 32'd12, 33);

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
